// File: rtl/register_checker.sv
// Hardware monitor for a 16-bit load register: keeps a golden shadow of the register,
// compares it with the observed output every RUN cycle, and counts and captures mismatches.
//
//   state  | meaning
//   IDLE   | waiting for start
//   ARM    | counters cleared, shadow syncs to the DUT, no compare
//   RUN    | compare, count, capture the first mismatch
//   DONE   | results held until start or reset
module register_checker #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 16,
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic [WIDTH-1:0] obs_in,
   input  logic             obs_load,
   input  logic [WIDTH-1:0] obs_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [CNT_W-1:0] cycle_count,
   output logic             err_valid,
   output logic [CNT_W-1:0] first_err_cycle,
   output logic [WIDTH-1:0] first_err_exp,
   output logic [WIDTH-1:0] first_err_got
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ARM  = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic             val_q, val_d;
   logic [CNT_W-1:0] fcyc_q, fcyc_d;
   logic [WIDTH-1:0] fexp_q, fexp_d;
   logic [WIDTH-1:0] fgot_q, fgot_d;
   logic             mismatch;
   logic             clr;

   assign mismatch = (obs_out != shadow_q);

   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      err_d    = err_q;
      cyc_d    = cyc_q;
      val_d    = val_q;
      fcyc_d   = fcyc_q;
      fexp_d   = fexp_q;
      fgot_d   = fgot_q;
      clr      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_ARM;
               clr     = 1'b1;
            end
         end
         S_ARM: begin
            shadow_d = obs_load ? obs_in : obs_out;
            state_d  = S_RUN;
         end
         S_RUN: begin
            shadow_d = obs_load ? obs_in : shadow_q;
            if (cyc_q != '1) cyc_d = cyc_q + 1'b1;
            if (mismatch) begin
               if (err_q != '1) err_d = err_q + 1'b1;
               if (!val_q) begin
                  val_d  = 1'b1;
                  fcyc_d = cyc_q;
                  fexp_d = shadow_q;
                  fgot_d = obs_out;
               end
            end
            if (stop || cyc_q == '1) state_d = S_DONE;
         end
         default: begin
            if (start) begin
               state_d = S_ARM;
               clr     = 1'b1;
            end
         end
      endcase
      // Clearing on start acceptance makes the cleared results visible as soon as ARM is entered.
      if (clr) begin
         err_d  = '0;
         cyc_d  = '0;
         val_d  = 1'b0;
         fcyc_d = '0;
         fexp_d = '0;
         fgot_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         shadow_q <= '0;
         err_q    <= '0;
         cyc_q    <= '0;
         val_q    <= 1'b0;
         fcyc_q   <= '0;
         fexp_q   <= '0;
         fgot_q   <= '0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         err_q    <= err_d;
         cyc_q    <= cyc_d;
         val_q    <= val_d;
         fcyc_q   <= fcyc_d;
         fexp_q   <= fexp_d;
         fgot_q   <= fgot_d;
      end
   end

   assign busy            = (state_q == S_ARM) || (state_q == S_RUN);
   assign done            = (state_q == S_DONE);
   assign pass            = (state_q == S_DONE) && (err_q == '0);
   assign err_count       = err_q;
   assign cycle_count     = cyc_q;
   assign err_valid       = val_q;
   assign first_err_cycle = fcyc_q;
   assign first_err_exp   = fexp_q;
   assign first_err_got   = fgot_q;

endmodule

// File: tb/tb_register_checker.sv
// Directed + randomized bench for register_checker; results are predicted from a per-run log
// of (expected, observed) pairs kept by the bench.
module tb_register_checker;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, stop, obs_load;
   logic [15:0] obs_in, obs_out;
   logic        busy, done, pass, err_valid;
   logic [7:0]  err_count;
   logic [15:0] cycle_count, first_err_cycle, first_err_exp, first_err_got;

   logic        start4, stop4;
   logic        busy4, done4, pass4, err_valid4;
   logic [7:0]  err_count4;
   logic [3:0]  cycle_count4, first_err_cycle4;
   logic [15:0] first_err_exp4, first_err_got4;

   always #5 clk = ~clk;

   register_checker #(.WIDTH(16), .CNT_W(16), .ERR_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
      .obs_in(obs_in), .obs_load(obs_load), .obs_out(obs_out),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .cycle_count(cycle_count), .err_valid(err_valid),
      .first_err_cycle(first_err_cycle), .first_err_exp(first_err_exp),
      .first_err_got(first_err_got));

   register_checker #(.WIDTH(16), .CNT_W(4), .ERR_W(8)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .stop(stop4),
      .obs_in(obs_in), .obs_load(obs_load), .obs_out(obs_out),
      .busy(busy4), .done(done4), .pass(pass4), .err_count(err_count4),
      .cycle_count(cycle_count4), .err_valid(err_valid4),
      .first_err_cycle(first_err_cycle4), .first_err_exp(first_err_exp4),
      .first_err_got(first_err_got4));

   int          errors = 0;
   int          checks = 0;
   string       cur = "reset";

   // checker model: 0 idle, 1 arm, 2 run, 3 done
   int          m_st = 0;
   logic [15:0] gold = '0;
   logic [15:0] q_exp[$];
   logic [15:0] q_got[$];
   // register-under-test model with fault knobs
   logic [15:0] dut_q = '0;
   int          skip_at = -1;
   bit          stuck = 1'b0;
   logic [15:0] flipmask = '0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s/%s got=%0h exp=%0h", cur, nm, got, exp);
      end
   endtask

   task automatic check_all();
      int nmis = 0;
      int first = -1;
      int ec;
      for (int i = 0; i < q_exp.size(); i++) begin
         if (q_exp[i] !== q_got[i]) begin
            nmis++;
            if (first < 0) first = i;
         end
      end
      ec = (nmis > 255) ? 255 : nmis;
      chk("busy", busy, (m_st == 1 || m_st == 2));
      chk("done", done, (m_st == 3));
      chk("pass", pass, (m_st == 3 && nmis == 0));
      chk("err_count", err_count, ec);
      chk("cycle_count", cycle_count, (q_exp.size() > 65535) ? 65535 : q_exp.size());
      chk("err_valid", err_valid, (first >= 0));
      chk("first_cycle", first_err_cycle, (first >= 0) ? first : 0);
      chk("first_exp", first_err_exp, (first >= 0) ? q_exp[first] : 16'h0);
      chk("first_got", first_err_got, (first >= 0) ? q_got[first] : 16'h0);
   endtask

   task automatic model_reset();
      m_st = 0;
      gold = '0;
      q_exp.delete();
      q_got.delete();
   endtask

   // One clock: drive inputs, advance both models, sample 1 time unit after the edge.
   task automatic cyc(input logic ld, input logic [15:0] din, input logic st, input logic sp);
      logic [15:0] got;
      bit          skip;
      got      = (stuck ? 16'h8000 : dut_q) ^ flipmask;
      obs_load = ld;
      obs_in   = din;
      obs_out  = got;
      start    = st;
      stop     = sp;
      skip     = (m_st == 2) && (q_exp.size() == skip_at);
      case (m_st)
         0: if (st) m_st = 1;
         1: begin
            gold = ld ? din : got;
            m_st = 2;
         end
         2: begin
            q_exp.push_back(gold);
            q_got.push_back(got);
            if (ld) gold = din;
            if (sp || q_exp.size() == 65536) m_st = 3;
         end
         default: if (st) m_st = 1;
      endcase
      if (m_st == 1 && st) begin
         q_exp.delete();
         q_got.delete();
      end
      if (ld && !skip) dut_q = din;
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      logic [15:0] vals[4];
      logic [15:0] w;
      vals[0] = 16'd0; vals[1] = 16'h8285; vals[2] = 16'd12345; vals[3] = 16'd0;
      rst_n = 1'b0; start = 0; stop = 0; obs_load = 0; obs_in = 0; obs_out = 0;
      start4 = 0; stop4 = 0;
      #12;
      check_all();
      #5 rst_n = 1'b1;

      // 1: correct DUT, 20 compare cycles
      cur = "t1";
      cyc(0, 0, 1, 0);
      cyc(1, 0, 0, 0);
      for (int c = 0; c < 20; c++)
         cyc((c % 3) != 2, vals[c % 4], 0, c == 19);
      chk("t1_done", done, 1);
      chk("t1_pass", pass, 1);
      chk("t1_cycles", cycle_count, 20);

      // 2: DUT drops the load at cycle 4, visible at compare cycle 5
      cur = "t2";
      skip_at = 4;
      cyc(0, 0, 1, 0);
      cyc(1, 0, 0, 0);
      for (int c = 0; c < 12; c++)
         cyc(c[0] == 1'b0, 16'(c), 0, c == 11);
      skip_at = -1;
      chk("t2_valid", err_valid, 1);
      chk("t2_fcyc", first_err_cycle, 5);
      chk("t2_fexp", first_err_exp, 4);
      chk("t2_fgot", first_err_got, 2);
      chk("t2_pass", pass, 0);

      // 3: output stuck at 0x8000, walking ones then zeros
      cur = "t3";
      stuck = 1'b1;
      cyc(0, 0, 1, 0);
      cyc(1, 16'h0001, 0, 0);
      for (int c = 0; c < 300; c++) begin
         w = 16'h1 << (c % 16);
         cyc(1, (c < 150) ? w : ~w, 0, c == 299);
      end
      stuck = 1'b0;
      chk("t3_sat", err_count, 255);
      chk("t3_cycles", cycle_count, 300);

      // random: correct register with occasional output glitches
      cur = "rnd";
      cyc(0, 0, 1, 0);
      cyc(1, 16'($urandom), 0, 0);
      for (int c = 0; c < 60; c++) begin
         flipmask = ($urandom_range(0, 7) == 0) ? (16'h1 << $urandom_range(0, 15)) : 16'h0;
         cyc(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), c == 59);
      end
      flipmask = '0;

      // 4: start+stop together at cycle 10, then restart
      cur = "t4";
      cyc(0, 0, 1, 0);
      cyc(1, 16'h1234, 0, 0);
      for (int c = 0; c < 10; c++) cyc(1, 16'($urandom), 1'(c == 3), 0);
      cyc(1, 16'h00ff, 1, 1);
      chk("t4_done", done, 1);
      chk("t4_cycles", cycle_count, 11);
      cyc(0, 0, 1, 0);
      chk("t4_busy", busy, 1);
      chk("t4_clr", cycle_count, 0);
      cyc(1, 16'h5555, 0, 0);
      for (int c = 0; c < 5; c++) cyc(1'(c[0]), 16'($urandom), 0, 0);

      // 5: asynchronous reset mid-run
      cur = "t5";
      rst_n = 1'b0;
      model_reset();
      dut_q = '0;
      #2;
      check_all();
      #2 rst_n = 1'b1;
      cyc(0, 0, 0, 1);
      cyc(1, 16'h0042, 0, 1);

      // 6: 4-bit counter instance runs to terminal count
      cur = "t6";
      start4 = 1'b1;
      cyc(0, 0, 0, 0);
      start4 = 1'b0;
      chk("t6_arm", busy4, 1);
      cyc(1, 16'h0007, 0, 0);
      for (int c = 0; c < 15; c++) cyc(1'(c[0]), 16'($urandom), 0, 0);
      chk("t6_cnt15", cycle_count4, 15);
      chk("t6_busy15", busy4, 1);
      chk("t6_nodone", done4, 0);
      cyc(1, 16'($urandom), 0, 0);
      chk("t6_done", done4, 1);
      chk("t6_cnt", cycle_count4, 15);
      chk("t6_pass", pass4, 1);
      for (int c = 0; c < 5; c++) cyc(1, 16'($urandom), 0, 0);
      chk("t6_hold", cycle_count4, 15);
      chk("t6_holddone", done4, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
